// File: rtl/mem_arb_pkg.sv
// Purpose: shared encodings for the memory port arbiter (FSM states, grant ids, latency default).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } gnt_t;

    localparam int MEM_LAT_DEF = 2;

    // The latency counter counts down to zero inside WAIT, so it is loaded
    // with one less than the memory latency (4 bits covers 1..15).
    function automatic logic [3:0] lat_load(input int lat);
        return 4'(lat - 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundle of the fetch port, data port and shared memory port of the arbiter.
// Latency: n/a (wires only).
// Backpressure: requesters hold req/addr/data until their ack; stall_* mirror that wait.
// Modports: slave  = arbiter view (requests and mem_rdata in; acks, rdata, memory strobe out)
//           master = environment view (requesters plus memory), directions mirrored.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    // fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    // data port
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;
    // shared memory port
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    // status
    logic              stall_if;
    logic              stall_dm;
    logic              busy;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ack, dm_rdata, dm_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output stall_if, stall_dm, busy
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ack, dm_rdata, dm_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  stall_if, stall_dm, busy
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Purpose: grant selection between fetch and data requesters.
// Latency: combinational.
// Backpressure: none; the caller decides when the grant is taken.
// Ports: if_req/dm_req in, last_grant in (used only with MEM_ARB_FAIR_EN), gnt_valid/gnt out.
// Build option: MEM_ARB_FAIR_EN selects alternating grants on contention; otherwise dm always wins.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic dm_req,
    input  gnt_t last_grant,
    output logic gnt_valid,
    output gnt_t gnt
);

`ifdef MEM_ARB_FAIR_EN
    always_comb begin
        gnt_valid = if_req | dm_req;
        gnt       = GNT_IF;
        if (if_req && dm_req) begin
            // On contention hand the grant to whichever port did not get the last one.
            gnt = (last_grant == GNT_IF) ? GNT_DM : GNT_IF;
        end else if (dm_req) begin
            gnt = GNT_DM;
        end
    end
`else
    // Fixed priority never looks at history; keep the port for a common footprint.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        gnt_valid = if_req | dm_req;
        gnt       = GNT_IF;
        if (dm_req) begin
            gnt = GNT_DM;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: share one single-ported memory between a fetch port and a data port.
// Latency: request sampled at edge 0 -> ack in cycle MEM_LAT+2; back-to-back every MEM_LAT+2 cycles.
// Backpressure: one access in flight; waiting requesters see stall_* = req & ~ack.
// Ports: clk, rst (synchronous, active-high), bus (mem_port_arbiter_if.slave).
// Build option: MEM_ARB_FAIR_EN enables alternating grants via a last_grant register.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam logic [3:0] CNT_LOAD = lat_load(MEM_LAT);

    state_t            state_q;
    state_t            state_d;
    gnt_t              gnt_q;
    gnt_t              pick_gnt;
    gnt_t              pick_last;
    logic              pick_vld;
    logic              take;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic [3:0]        cnt_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              rd_done;
    logic              mem_en_c;
    logic              mem_we_c;
    logic              if_ack_c;
    logic              dm_ack_c;
    logic              busy_c;

    mem_arb_pick u_pick (
        .if_req     (bus.if_req),
        .dm_req     (bus.dm_req),
        .last_grant (pick_last),
        .gnt_valid  (pick_vld),
        .gnt        (pick_gnt)
    );

`ifdef MEM_ARB_FAIR_EN
    gnt_t last_grant_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GNT_IF;
        end else if (take) begin
            last_grant_q <= pick_gnt;
        end
    end

    assign pick_last = last_grant_q;
`else
    assign pick_last = GNT_IF;
`endif

    // A new grant is accepted from IDLE, or straight out of RESP so that
    // back-to-back accesses skip the idle cycle.
    assign take    = pick_vld && ((state_q == IDLE) || (state_q == RESP));
    assign rd_done = (state_q == WAIT) && (cnt_q == 4'd0) && !we_q;

    always_comb begin
        state_d  = state_q;
        mem_en_c = 1'b0;
        mem_we_c = 1'b0;
        if_ack_c = 1'b0;
        dm_ack_c = 1'b0;
        busy_c   = 1'b1;
        case (state_q)
            IDLE: begin
                busy_c = 1'b0;
                if (pick_vld) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem_en_c = 1'b1;
                mem_we_c = we_q;
                state_d  = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if_ack_c = (gnt_q == GNT_IF);
                dm_ack_c = (gnt_q == GNT_DM);
                state_d  = pick_vld ? ISSUE : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= GNT_IF;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            cnt_q      <= 4'd0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q <= state_d;

            // Requester values are only looked at on the grant edge.
            if (take) begin
                gnt_q <= pick_gnt;
                if (pick_gnt == GNT_DM) begin
                    addr_q  <= bus.dm_addr;
                    wdata_q <= bus.dm_wdata;
                    we_q    <= bus.dm_we;
                end else begin
                    addr_q  <= bus.if_addr;
                    wdata_q <= '0;
                    we_q    <= 1'b0;
                end
            end

            if (state_q == ISSUE) begin
                cnt_q <= CNT_LOAD;
            end else if ((state_q == WAIT) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end

            if (rd_done) begin
                if (gnt_q == GNT_DM) begin
                    dm_rdata_q <= bus.mem_rdata;
                end else begin
                    if_rdata_q <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_en    = mem_en_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_ack    = if_ack_c;
    assign bus.dm_ack    = dm_ack_c;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.busy      = busy_c;
    assign bus.stall_if  = bus.if_req & ~if_ack_c;
    assign bus.stall_dm  = bus.dm_req & ~dm_ack_c;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: self-checking bench for mem_port_arbiter (default latency instance plus a MEM_LAT=1 instance).
// Latency: expectations derived from MEM_LAT+2 cycles per access.
// Backpressure: requesters hold requests until their ack, then drop them.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;
`ifdef MEM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus  ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] init_word(input int i);
        return 32'h9E3779B9 * (i + 1);
    endfunction

    // ---------------- memory behind the default instance ----------------
    // Read data is only valid exactly MEM_LAT cycles after the strobe; any
    // other time the bus carries junk, so a mistimed capture shows up.
    logic [31:0] mem_arr [0:255];
    logic [31:0] rd_pend;
    int          rd_cnt;
    logic        poke_vld;
    logic [7:0]  poke_idx;
    logic [31:0] poke_dat;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= init_word(i);
            rd_cnt <= 0;
        end else begin
            if (poke_vld) mem_arr[poke_idx] <= poke_dat;
            if (bus.mem_en && bus.mem_we) mem_arr[bus.mem_addr[9:2]] <= bus.mem_wdata;
            if (bus.mem_en && !bus.mem_we) begin
                rd_pend <= mem_arr[bus.mem_addr[9:2]];
                rd_cnt  <= LAT;
            end else if (rd_cnt > 0) begin
                rd_cnt <= rd_cnt - 1;
            end
        end
    end

    assign bus.mem_rdata  = (rd_cnt == 1) ? rd_pend : 32'hBADC0FFE;
    assign bus1.mem_rdata = {16'hA5A5, bus1.mem_addr[15:0]};

    // ---------------- reference model state ----------------
    logic [31:0] ref_mem [0:255];
    logic [31:0] if_rd_m;
    logic [31:0] dm_rd_m;
    gnt_t        last_g;

    task automatic model_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        if_rd_m = '0;
        dm_rd_m = '0;
        last_g  = GNT_IF;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One request per port at most, both raised in cycle 0.
    task automatic do_txn(input bit use_if, input bit use_dm, input bit we,
                          input logic [31:0] ia, input logic [31:0] da,
                          input logic [31:0] wd, input bit drop_early);
        int          p, n, last, if_cyc, dm_cyc;
        bit          dm_first, slot_dm;
        logic [31:0] exp_if_rd, exp_dm_rd;
        p         = LAT + 2;
        n         = int'(use_if) + int'(use_dm);
        dm_first  = use_dm && (!use_if || !FAIR || last_g == GNT_IF);
        last      = n * p;
        if_cyc    = !use_if ? -1 : (dm_first ? 2 * p : p);
        dm_cyc    = !use_dm ? -1 : (dm_first ? p : 2 * p);
        exp_if_rd = use_if ? ref_mem[ia[9:2]] : if_rd_m;
        exp_dm_rd = (use_dm && !we) ? ref_mem[da[9:2]] : dm_rd_m;

        @(posedge clk); #1;
        bus.if_req   = use_if;
        bus.if_addr  = ia;
        bus.dm_req   = use_dm;
        bus.dm_we    = we;
        bus.dm_addr  = da;
        bus.dm_wdata = wd;
        for (int c = 0; c <= last + 1; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                if (drop_early && c == 1) begin
                    // Dropped and garbled after the grant edge: must not matter.
                    bus.if_req   = 1'b0;
                    bus.dm_req   = 1'b0;
                    bus.if_addr  = $urandom;
                    bus.dm_addr  = $urandom;
                    bus.dm_wdata = $urandom;
                    bus.dm_we    = ~we;
                end
            end
            @(negedge clk);
            chk1($sformatf("if_ack c%0d", c), bus.if_ack, c == if_cyc);
            chk1($sformatf("dm_ack c%0d", c), bus.dm_ack, c == dm_cyc);
            chk1($sformatf("stall_if c%0d", c), bus.stall_if, bus.if_req && c != if_cyc);
            chk1($sformatf("stall_dm c%0d", c), bus.stall_dm, bus.dm_req && c != dm_cyc);
            chk1($sformatf("mem_en c%0d", c), bus.mem_en, c == 1 || (n == 2 && c == p + 1));
            chk1($sformatf("busy c%0d", c), bus.busy, c >= 1 && c <= last);
            if (c == 1 || (n == 2 && c == p + 1)) begin
                slot_dm = (c == 1) ? dm_first : !dm_first;
                chk32($sformatf("mem_addr c%0d", c), bus.mem_addr, slot_dm ? da : ia);
                chk1($sformatf("mem_we c%0d", c), bus.mem_we, slot_dm && we);
                if (slot_dm && we) chk32($sformatf("mem_wdata c%0d", c), bus.mem_wdata, wd);
            end
            if (c == if_cyc) begin
                chk32("if_rdata at ack", bus.if_rdata, exp_if_rd);
                bus.if_req = 1'b0;
            end
            if (c == dm_cyc) begin
                chk32("dm_rdata at ack", bus.dm_rdata, exp_dm_rd);
                bus.dm_req = 1'b0;
            end
            if (c == last + 1) begin
                chk32("if_rdata hold", bus.if_rdata, exp_if_rd);
                chk32("dm_rdata hold", bus.dm_rdata, exp_dm_rd);
            end
        end

        if_rd_m = exp_if_rd;
        dm_rd_m = exp_dm_rd;
        if (use_dm && we) ref_mem[da[9:2]] = wd;
        if (n == 2)      last_g = dm_first ? GNT_IF : GNT_DM;
        else if (use_dm) last_g = GNT_DM;
        else if (use_if) last_g = GNT_IF;
    endtask

    // Both ports keep requesting reads for three consecutive grants.
    task automatic hold_both(input logic [31:0] ia, input logic [31:0] da);
        int          p;
        gnt_t        g;
        gnt_t        seq [3];
        logic        exp_if, exp_dm, ack_slot;
        logic [31:0] exp_if_rd, exp_dm_rd;
        p = LAT + 2;
        g = FAIR ? ((last_g == GNT_IF) ? GNT_DM : GNT_IF) : GNT_DM;
        exp_if_rd = if_rd_m;
        exp_dm_rd = dm_rd_m;
        for (int k = 0; k < 3; k++) begin
            seq[k] = g;
            if (g == GNT_IF) exp_if_rd = ref_mem[ia[9:2]];
            else             exp_dm_rd = ref_mem[da[9:2]];
            if (FAIR) g = (g == GNT_DM) ? GNT_IF : GNT_DM;
        end

        @(posedge clk); #1;
        bus.if_req  = 1'b1;
        bus.if_addr = ia;
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = da;
        for (int c = 0; c <= 3 * p + 1; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            ack_slot = (c > 0) && (c % p == 0) && (c <= 3 * p);
            exp_if   = 1'b0;
            exp_dm   = 1'b0;
            if (ack_slot) begin
                exp_if = (seq[c / p - 1] == GNT_IF);
                exp_dm = (seq[c / p - 1] == GNT_DM);
            end
            chk1($sformatf("hold if_ack c%0d", c), bus.if_ack, exp_if);
            chk1($sformatf("hold dm_ack c%0d", c), bus.dm_ack, exp_dm);
            chk1($sformatf("hold stall_if c%0d", c), bus.stall_if, bus.if_req && !exp_if);
            chk1($sformatf("hold mem_en c%0d", c), bus.mem_en, c <= 3 * p && c % p == 1);
            chk1($sformatf("hold busy c%0d", c), bus.busy, c >= 1 && c <= 3 * p);
            if (exp_if) chk32("hold if_rdata", bus.if_rdata, ref_mem[ia[9:2]]);
            if (exp_dm) chk32("hold dm_rdata", bus.dm_rdata, ref_mem[da[9:2]]);
            if (c == 3 * p) begin
                bus.if_req = 1'b0;
                bus.dm_req = 1'b0;
            end
        end
        last_g  = seq[2];
        if_rd_m = exp_if_rd;
        dm_rd_m = exp_dm_rd;
    endtask

    task automatic reset_mid();
        @(posedge clk); #1;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h44;
        @(negedge clk);
        chk1("rst_mid stall_if c0", bus.stall_if, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("rst_mid mem_en c1", bus.mem_en, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk1("rst_mid busy c2", bus.busy, 1'b1);
        @(posedge clk); #1;
        rst        = 1'b0;
        bus.if_req = 1'b0;
        model_reset();
        @(negedge clk);
        chk1("rst_mid busy c3", bus.busy, 1'b0);
        chk1("rst_mid mem_en c3", bus.mem_en, 1'b0);
        chk1("rst_mid mem_we c3", bus.mem_we, 1'b0);
        chk32("rst_mid mem_addr c3", bus.mem_addr, 32'h0);
        chk32("rst_mid if_rdata c3", bus.if_rdata, 32'h0);
        chk32("rst_mid dm_rdata c3", bus.dm_rdata, 32'h0);
        for (int c = 4; c < 10; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk1($sformatf("rst_mid if_ack c%0d", c), bus.if_ack, 1'b0);
            chk1($sformatf("rst_mid mem_en c%0d", c), bus.mem_en, 1'b0);
        end
    endtask

    task automatic lat1_stream();
        @(posedge clk); #1;
        bus1.if_req  = 1'b1;
        bus1.if_addr = 32'h0ABC;
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            chk1($sformatf("lat1 if_ack c%0d", c), bus1.if_ack, c > 0 && c % 3 == 0);
            chk1($sformatf("lat1 mem_en c%0d", c), bus1.mem_en, c % 3 == 1);
            if (c > 0 && c % 3 == 0) chk32("lat1 if_rdata", bus1.if_rdata, 32'hA5A50ABC);
            if (c == 12) bus1.if_req = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] ia, da;
        int          mode;
        rst           = 1'b1;
        poke_vld      = 1'b0;
        poke_idx      = '0;
        poke_dat      = '0;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.dm_req    = 1'b0;
        bus.dm_we     = 1'b0;
        bus.dm_addr   = '0;
        bus.dm_wdata  = '0;
        bus1.if_req   = 1'b0;
        bus1.if_addr  = '0;
        bus1.dm_req   = 1'b0;
        bus1.dm_we    = 1'b0;
        bus1.dm_addr  = '0;
        bus1.dm_wdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk1("reset busy", bus.busy, 1'b0);
        chk1("reset mem_en", bus.mem_en, 1'b0);
        chk1("reset mem_we", bus.mem_we, 1'b0);
        chk32("reset mem_addr", bus.mem_addr, 32'h0);
        chk32("reset mem_wdata", bus.mem_wdata, 32'h0);
        chk1("reset if_ack", bus.if_ack, 1'b0);
        chk1("reset dm_ack", bus.dm_ack, 1'b0);
        chk32("reset if_rdata", bus.if_rdata, 32'h0);
        chk32("reset dm_rdata", bus.dm_rdata, 32'h0);
        chk1("reset stall_if", bus.stall_if, 1'b0);

        // fetch read of 0x40 returning 0x1234ABCD
        @(posedge clk); #1;
        poke_vld = 1'b1;
        poke_idx = 8'd16;
        poke_dat = 32'h1234ABCD;
        ref_mem[16] = 32'h1234ABCD;
        @(posedge clk); #1;
        poke_vld = 1'b0;
        do_txn(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0);

        // simultaneous requests: dm first, if acks in cycle 8
        do_txn(1'b1, 1'b1, 1'b0, 32'h80, 32'h300, 32'h0, 1'b0);
        hold_both(32'h84, 32'h304);

        // data write, then fetch it back
        do_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h100, 32'hDEADBEEF, 1'b0);
        do_txn(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 1'b0);

        // requests withdrawn right after the grant still complete
        do_txn(1'b1, 1'b0, 1'b0, 32'h1C, 32'h0, 32'h0, 1'b1);
        do_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h208, 32'h0, 1'b1);

        reset_mid();
        do_txn(1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 32'h0, 1'b0);

        for (int it = 0; it < 24; it++) begin
            mode = $urandom_range(0, 2);
            ia   = {22'b0, 1'b0, 7'($urandom_range(0, 127)), 2'b00};
            da   = {22'b0, 1'b1, 7'($urandom_range(0, 127)), 2'b00};
            do_txn(mode != 1, mode != 0, 1'($urandom_range(0, 1)), ia, da, $urandom,
                   (mode != 2) && ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        lat1_stream();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameters (name, default, meaning): ADDR_W, 32, address width; DATA_W, 32, data width; MEM_LAT, 2, memory read latency in cycles (legal range 1..15).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high; ports `clk` and `rst`.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetch data
- if_ack  out  1  fetch done pulse
- dm_req  in  1  data request
- dm_we  in  1  data write
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  data write value
- dm_rdata  out  DATA_W  data read value
- dm_ack  out  1  data done pulse
- mem_en  out  1  memory strobe
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- stall_if  out  1  fetch stall
- stall_dm  out  1  data stall
- busy  out  1  transaction in flight

Function
REQ-004 The FSM SHALL have four states: IDLE, ISSUE, WAIT and RESP; busy SHALL be 1 in every state except IDLE.
REQ-005 In IDLE, any request sampled at a clock edge SHALL latch the grant, the address, the write data and the write flag, and SHALL move the FSM to ISSUE.
REQ-006 In ISSUE, mem_en SHALL be 1 for exactly one cycle, and mem_addr/mem_wdata/mem_we SHALL be driven from the latched values; the latency counter SHALL load MEM_LAT-1; the FSM SHALL go to WAIT.
REQ-007 In WAIT, mem_en SHALL be 0 and the counter SHALL decrement; at the count of 0, a read SHALL capture mem_rdata into the granted port's rdata register, and the FSM SHALL go to RESP.
REQ-008 In RESP, the granted port's ack SHALL be 1 for exactly one cycle; a request pending at that edge SHALL cause the FSM to go directly to ISSUE, and otherwise to IDLE.
REQ-009 Latency: request sampled at edge 0 -> ack high in cycle MEM_LAT+2 (cycle 4 at the default); one access SHALL complete every MEM_LAT+2 cycles back-to-back.
REQ-010 Default arbitration SHALL be fixed priority, with dm winning over if on simultaneous requests.
REQ-011 A write SHALL leave dm_rdata unchanged and SHALL still pulse dm_ack.
REQ-012 The rdata outputs SHALL hold their value until the next read completes on that same port.
REQ-013 stall_if SHALL equal if_req & ~if_ack, and stall_dm SHALL equal dm_req & ~dm_ack; both SHALL be combinational.
REQ-014 A request dropped mid-transaction SHALL NOT abort the access; the access SHALL complete and the ack SHALL still pulse.
REQ-015 Requesters SHALL hold req/addr/data stable until ack; values sampled after the grant edge SHALL be ignored.

Reset
REQ-016 While rst=1 at an edge, the block SHALL enter IDLE with counter=0 and last_grant=IF, and the outputs SHALL be: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, acks=0, if_rdata=0, dm_rdata=0, busy=0.
REQ-017 A reset asserted mid-transaction SHALL abandon that transaction with no ack and no further mem_en.

Configuration
REQ-018 With macro MEM_ARB_FAIR_EN defined, simultaneous requests SHALL be granted to the port not in last_grant, and last_grant SHALL update on every grant.
REQ-019 With MEM_ARB_FAIR_EN undefined, REQ-010 fixed priority SHALL apply and no last_grant register SHALL exist.

Structure
REQ-020 A shared package mem_arb_pkg SHALL hold the state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3), the grant encoding (GNT_IF=0, GNT_DM=1) and the MEM_LAT default.
REQ-021 Grant selection SHALL be a sub-module mem_arb_pick with inputs (if_req, dm_req, last_grant) and outputs (gnt_valid, gnt); it SHALL contain fixed-priority and round-robin logic under the macro.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- if_req=1, if_addr=0x40, mem_rdata returns 0x1234ABCD -> mem_en pulses in cycle 1; if_ack=1 in cycle 4; if_rdata=0x1234ABCD.
- if_req and dm_req both 1 from cycle 0, fair disabled -> dm granted first; if_ack in cycle 8; stall_if=1 in cycles 0-7.
- Same stimulus with MEM_ARB_FAIR_EN -> dm first, then if; with both held, grants alternate dm, if, dm.
- dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF -> mem_we=1 and mem_wdata=0xDEADBEEF during ISSUE; dm_ack in cycle 4; dm_rdata unchanged.
- rst=1 in cycle 2 of a read -> no ack; busy=0 next cycle; a new request completes normally.
- MEM_LAT=1, continuous if_req -> if_ack every 3 cycles, and mem_en never asserted twice within 3 cycles.
